rw_manager_ac_issue: RTL and testbench

Address/command issue engine placed directly in front of the AC instruction ROM (64 × 32-bit, two-cycle read latency) in the DDR3 read/write manager. It accepts a sequence request from the calibration sequencer, walks ROM addresses one per cycle, tracks the ROM pipeline latency, and decodes each returned instruction word into registered DDR3 address/command pins with a valid qualifier. Whole sequences can be looped a programmable number of times. A done pulse is issued when the last decoded word leaves the block.

---
 rtl/rw_manager_ac_pkg.sv | 77 +++++++
 rtl/rw_manager_ac_issue_if.sv | 38 +++
 rtl/rw_manager_ac_decode.sv | 55 +++++
 rtl/rw_manager_ac_issue.sv | 155 +++++++++++++++
 tb/tb_rw_manager_ac_issue.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rw_manager_ac_pkg.sv
// Shared definitions for the AC issue engine and its output decoder.
// ROM word layout, engine states and pin bundle types.
package rw_manager_ac_pkg;

    localparam int A_LSB       = 0;
    localparam int A_W         = 16;
    localparam int BA_LSB      = 16;
    localparam int BA_W        = 3;
    localparam int WE_N_BIT    = 19;
    localparam int CAS_N_BIT   = 20;
    localparam int RAS_N_BIT   = 21;
    localparam int ODT_BIT     = 22;
    localparam int CS_N_BIT    = 23;
    localparam int RD_BIT      = 24;
    localparam int WR_BIT      = 25;
    localparam int CKE_BIT     = 26;
    localparam int RESET_N_BIT = 27;
    localparam int FIELD_W     = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [A_W-1:0]  a;
        logic [BA_W-1:0] ba;
        logic            cs_n;
        logic            ras_n;
        logic            cas_n;
        logic            we_n;
        logic            odt;
        logic            cke;
        logic            reset_n;
        logic            rd_issue;
        logic            wr_issue;
    } ac_pins_t;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
        logic rd_issue;
        logic wr_issue;
    } ac_cmd_t;

    localparam ac_cmd_t AC_CMD_NOP = '{
        cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
        rd_issue: 1'b0, wr_issue: 1'b0
    };

    localparam ac_pins_t AC_PINS_RST = '{
        a: '0, ba: '0,
        cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
        odt: 1'b0, cke: 1'b0, reset_n: 1'b0,
        rd_issue: 1'b0, wr_issue: 1'b0
    };

    function automatic ac_pins_t unpack_word(input logic [FIELD_W-1:0] w);
        ac_pins_t p;
        p.a        = w[A_LSB +: A_W];
        p.ba       = w[BA_LSB +: BA_W];
        p.we_n     = w[WE_N_BIT];
        p.cas_n    = w[CAS_N_BIT];
        p.ras_n    = w[RAS_N_BIT];
        p.odt      = w[ODT_BIT];
        p.cs_n     = w[CS_N_BIT];
        p.rd_issue = w[RD_BIT];
        p.wr_issue = w[WR_BIT];
        p.cke      = w[CKE_BIT];
        p.reset_n  = w[RESET_N_BIT];
        return p;
    endfunction

endpackage

// File: rtl/rw_manager_ac_issue_if.sv
// Sequence request handshake between the calibration sequencer
// (master) and the AC issue engine (slave).
interface rw_manager_ac_issue_if #(
    parameter int ADDR_W = 6
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_start;
    logic [ADDR_W-1:0] cmd_len;
    logic [7:0]        cmd_repeat;
    logic              abort;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_len,
        output cmd_repeat,
        output abort,
        input  cmd_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_len,
        input  cmd_repeat,
        input  abort,
        output cmd_ready,
        output busy,
        output done
    );

endinterface

// File: rtl/rw_manager_ac_decode.sv
// Registered ROM-word unpack with NOP insertion on idle cycles.
// Address, bank, odt, cke and reset_n hold while no word is loaded.
module rw_manager_ac_decode
    import rw_manager_ac_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] word_i,
    output logic              valid_o,
    output ac_pins_t          pins_o
);

    ac_pins_t pins_d;
    ac_pins_t pins_q;
    logic     valid_d;
    logic     valid_q;
    logic     unused_rsvd;

    assign unused_rsvd = ^word_i[DATA_W-1:FIELD_W];

    // Load a fresh word, or force the command pins to NOP.
    always_comb begin
        pins_d  = pins_q;
        valid_d = 1'b0;
        if (valid_i) begin
            pins_d  = unpack_word(word_i[FIELD_W-1:0]);
            valid_d = 1'b1;
        end else begin
            pins_d.cs_n     = AC_CMD_NOP.cs_n;
            pins_d.ras_n    = AC_CMD_NOP.ras_n;
            pins_d.cas_n    = AC_CMD_NOP.cas_n;
            pins_d.we_n     = AC_CMD_NOP.we_n;
            pins_d.rd_issue = AC_CMD_NOP.rd_issue;
            pins_d.wr_issue = AC_CMD_NOP.wr_issue;
        end
    end

    // Output pin register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pins_q  <= AC_PINS_RST;
            valid_q <= 1'b0;
        end else begin
            pins_q  <= pins_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign pins_o  = pins_q;

endmodule

// File: rtl/rw_manager_ac_issue.sv
// AC issue engine: walks ROM addresses, tracks ROM latency with a
// valid shift register and feeds the registered pin decoder.
module rw_manager_ac_issue
    import rw_manager_ac_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    rw_manager_ac_issue_if.slave cmd,
    output logic [ADDR_W-1:0]   rom_rdaddress,
    input  logic [DATA_W-1:0]   rom_q,
    output logic                ac_valid,
    output logic [15:0]         mem_a,
    output logic [2:0]          mem_ba,
    output logic                mem_cs_n,
    output logic                mem_ras_n,
    output logic                mem_cas_n,
    output logic                mem_we_n,
    output logic                mem_odt,
    output logic                mem_cke,
    output logic                mem_reset_n,
    output logic                rd_issue,
    output logic                wr_issue
);

    state_e             state_d;
    state_e             state_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  word_d;
    logic [ADDR_W-1:0]  word_q;
    logic [ADDR_W-1:0]  start_d;
    logic [ADDR_W-1:0]  start_q;
    logic [ADDR_W-1:0]  len_d;
    logic [ADDR_W-1:0]  len_q;
    logic [7:0]         pass_d;
    logic [7:0]         pass_q;
    logic [ROM_LAT-1:0] vld_d;
    logic [ROM_LAT-1:0] vld_q;
    logic               done_c;
    logic               abort_c;
    logic               dec_valid;
    ac_pins_t           pins;

    assign abort_c = cmd.abort && (state_q != ST_IDLE);

    // Next-state, counters and latency tracking; abort wins over all.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        start_d = start_q;
        len_d   = len_q;
        pass_d  = pass_q;
        vld_d   = vld_q;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    start_d = cmd.cmd_start;
                    len_d   = cmd.cmd_len;
                    pass_d  = cmd.cmd_repeat;
                    addr_d  = cmd.cmd_start;
                    word_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                vld_d = (vld_q << 1) | ROM_LAT'(1);
                if (word_q == len_q) begin
                    if (pass_q != 8'd0) begin
                        pass_d = pass_q - 8'd1;
                        addr_d = start_q;
                        word_d = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_DRAIN;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    word_d = word_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                vld_d = vld_q << 1;
                if (vld_q == '0) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_c) begin
            vld_d   = '0;
            state_d = ST_IDLE;
            done_c  = 1'b0;
        end
    end

    // Engine state and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            start_q <= '0;
            len_q   <= '0;
            pass_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            start_q <= start_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            vld_q   <= vld_d;
        end
    end

    assign dec_valid     = vld_q[ROM_LAT-1] && !abort_c;
    assign rom_rdaddress = addr_q;
    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign cmd.busy      = (state_q != ST_IDLE);
    assign cmd.done      = done_c;

    rw_manager_ac_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (dec_valid),
        .word_i  (rom_q),
        .valid_o (ac_valid),
        .pins_o  (pins)
    );

    assign mem_a       = pins.a;
    assign mem_ba      = pins.ba;
    assign mem_cs_n    = pins.cs_n;
    assign mem_ras_n   = pins.ras_n;
    assign mem_cas_n   = pins.cas_n;
    assign mem_we_n    = pins.we_n;
    assign mem_odt     = pins.odt;
    assign mem_cke     = pins.cke;
    assign mem_reset_n = pins.reset_n;
    assign rd_issue    = pins.rd_issue;
    assign wr_issue    = pins.wr_issue;

endmodule

// File: tb/tb_rw_manager_ac_issue.sv
// Directed bench for rw_manager_ac_issue with a 2-cycle ROM model.
// Words at 02/03/04 carry fixed mem_a values; others carry A000+addr.
module tb_rw_manager_ac_issue;

    logic        clock;
    logic        reset_n;
    logic [5:0]  rom_rdaddress;
    logic [31:0] rom_q;
    logic        ac_valid;
    logic [15:0] mem_a;
    logic [2:0]  mem_ba;
    logic        mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;
    logic        mem_odt, mem_cke, mem_reset_n;
    logic        rd_issue, wr_issue;

    rw_manager_ac_issue_if #(.ADDR_W(6)) cmd_if ();

    rw_manager_ac_issue #(
        .ADDR_W  (6),
        .DATA_W  (32),
        .ROM_LAT (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cmd           (cmd_if.slave),
        .rom_rdaddress (rom_rdaddress),
        .rom_q         (rom_q),
        .ac_valid      (ac_valid),
        .mem_a         (mem_a),
        .mem_ba        (mem_ba),
        .mem_cs_n      (mem_cs_n),
        .mem_ras_n     (mem_ras_n),
        .mem_cas_n     (mem_cas_n),
        .mem_we_n      (mem_we_n),
        .mem_odt       (mem_odt),
        .mem_cke       (mem_cke),
        .mem_reset_n   (mem_reset_n),
        .rd_issue      (rd_issue),
        .wr_issue      (wr_issue)
    );

    logic [31:0] rom [64];
    logic [31:0] rom_r1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          av_cyc[$];
    logic [15:0] av_a[$];
    int          done_cyc[$];
    int          busy_n = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        rom_r1 <= rom[rom_rdaddress];
        rom_q  <= rom_r1;
    end

    always @(negedge clock) begin
        if (ac_valid) begin
            av_cyc.push_back(cyc);
            av_a.push_back(mem_a);
        end
        if (cmd_if.done) done_cyc.push_back(cyc);
        if (cmd_if.busy) busy_n = busy_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [5:0] start, input logic [5:0] len,
                          input logic [7:0] rep, output int t0);
        @(negedge clock);
        cmd_if.cmd_start  = start;
        cmd_if.cmd_len    = len;
        cmd_if.cmd_repeat = rep;
        cmd_if.cmd_valid  = 1'b1;
        @(posedge clock);
        #1;
        cmd_if.cmd_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!cmd_if.cmd_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(cmd_if.cmd_ready), 32'd1);
        @(negedge clock);
    endtask

    task automatic check_addrs(input string tag, input logic [5:0] a_exp[$]);
        foreach (a_exp[i]) begin
            @(negedge clock);
            check(tag, 32'(rom_rdaddress), 32'(a_exp[i]));
            @(posedge clock);
        end
    endtask

    task automatic check_run(input string tag, input int base, input int t0,
                             input logic [15:0] a_exp[$]);
        check({tag, "_nvalid"}, 32'(av_cyc.size() - base), 32'(a_exp.size()));
        foreach (a_exp[i]) begin
            if (base + i < av_cyc.size()) begin
                check({tag, "_vcyc"}, 32'(av_cyc[base + i]), 32'(t0 + 3 + i));
                check({tag, "_mema"}, 32'(av_a[base + i]), 32'(a_exp[i]));
            end
        end
    endtask

    task automatic check_done(input string tag, input int base, input int b0,
                              input int done_at, input int busy_exp);
        check({tag, "_ndone"}, 32'(done_cyc.size() - base), 32'd1);
        if (done_cyc.size() > base)
            check({tag, "_donecyc"}, 32'(done_cyc[base]), 32'(done_at));
        check({tag, "_busy"}, 32'(busy_n - b0), 32'(busy_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0, vb, db, bb;
        logic [5:0] b;
        logic [15:0] a;
        for (int i = 0; i < 64; i++) begin
            b = 6'(i);
            a = 16'hA000 + 16'(i);
            if (i == 2) a = 16'h0231;
            if (i == 3) a = 16'h0330;
            if (i == 4) a = 16'h2000;
            rom[i] = {4'hF, 1'b1, 1'b1, ~b[0], b[0], 1'b0, 1'b1,
                      b[2], b[1], b[0], b[2:0], a};
        end
        reset_n           = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_start  = '0;
        cmd_if.cmd_len    = '0;
        cmd_if.cmd_repeat = '0;
        cmd_if.abort      = 1'b0;
        #22;
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst_busy", 32'(cmd_if.busy), 32'd0);
        check("rst_done", 32'(cmd_if.done), 32'd0);
        check("rst_valid", 32'(ac_valid), 32'd0);
        check("rst_addr", 32'(rom_rdaddress), 32'd0);
        check("rst_a_ba", {13'd0, mem_ba, mem_a}, 32'd0);
        check("rst_cmd", {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n}, 32'hF);
        check("rst_misc", {mem_odt, mem_cke, mem_reset_n, rd_issue, wr_issue},
              32'd0);

        // start 02, len 2
        vb = av_cyc.size(); db = done_cyc.size(); bb = busy_n;
        do_req(6'h02, 6'd2, 8'd0, t0);
        check_addrs("t1_addr", '{6'h02, 6'h03, 6'h04});
        @(negedge clock);
        check("t1_w0_ba", 32'(mem_ba), 32'd2);
        check("t1_w0_cmd", {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n}, 32'h2);
        check("t1_w0_rdwr", {rd_issue, wr_issue}, 32'h1);
        check("t1_w0_misc", {mem_odt, mem_cke, mem_reset_n}, 32'h7);
        wait_idle("t1_idle");
        check_run("t1", vb, t0, '{16'h0231, 16'h0330, 16'h2000});
        check_done("t1", db, bb, t0 + 5, 6);
        check("t1_nop_cs", 32'(mem_cs_n), 32'd1);
        check("t1_nop_rdwr", {rd_issue, wr_issue}, 32'd0);
        check("t1_hold_a", 32'(mem_a), 32'h2000);

        // wrap 3E..01
        vb = av_cyc.size(); db = done_cyc.size(); bb = busy_n;
        do_req(6'h3E, 6'd3, 8'd0, t0);
        check_addrs("t2_addr", '{6'h3E, 6'h3F, 6'h00, 6'h01});
        wait_idle("t2_idle");
        check_run("t2", vb, t0, '{16'hA03E, 16'hA03F, 16'hA000, 16'hA001});
        check_done("t2", db, bb, t0 + 6, 7);

        // repeat 2, with an ignored request mid-sequence
        vb = av_cyc.size(); db = done_cyc.size(); bb = busy_n;
        do_req(6'h14, 6'd1, 8'd2, t0);
        check_addrs("t3_addr", '{6'h14, 6'h15});
        cmd_if.cmd_start = 6'h30;
        cmd_if.cmd_valid = 1'b1;
        check_addrs("t3_addr", '{6'h14});
        cmd_if.cmd_valid = 1'b0;
        check_addrs("t3_addr", '{6'h15, 6'h14, 6'h15});
        wait_idle("t3_idle");
        check_run("t3", vb, t0, '{16'hA014, 16'hA015, 16'hA014,
                                  16'hA015, 16'hA014, 16'hA015});
        check_done("t3", db, bb, t0 + 8, 9);
        check("t3_no_requeue", 32'(cmd_if.busy), 32'd0);

        // abort after first ac_valid of a 4-word sequence
        vb = av_cyc.size(); db = done_cyc.size();
        do_req(6'h06, 6'd3, 8'd0, t0);
        repeat (4) @(posedge clock);
        #1 cmd_if.abort = 1'b1;
        @(posedge clock);
        #1 cmd_if.abort = 1'b0;
        @(negedge clock);
        check("t4_valid", 32'(ac_valid), 32'd0);
        check("t4_cs_n", 32'(mem_cs_n), 32'd1);
        check("t4_cmd", {mem_ras_n, mem_cas_n, mem_we_n}, 32'h7);
        check("t4_ready", 32'(cmd_if.cmd_ready), 32'd1);
        repeat (8) @(negedge clock);
        check("t4_nvalid", 32'(av_cyc.size() - vb), 32'd2);
        check("t4_ndone", 32'(done_cyc.size() - db), 32'd0);

        // asynchronous reset mid-ISSUE
        do_req(6'h20, 6'd10, 8'd0, t0);
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("t5_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("t5_busy", 32'(cmd_if.busy), 32'd0);
        check("t5_addr", 32'(rom_rdaddress), 32'd0);
        check("t5_mema", 32'(mem_a), 32'd0);
        check("t5_cmd", {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n}, 32'hF);
        check("t5_misc", {mem_odt, mem_cke, mem_reset_n}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        vb = av_cyc.size(); db = done_cyc.size(); bb = busy_n;
        do_req(6'h02, 6'd0, 8'd0, t0);
        check_addrs("t5_addr", '{6'h02});
        wait_idle("t5_idle");
        check_run("t5", vb, t0, '{16'h0231});
        check_done("t5", db, bb, t0 + 3, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
